// File: rtl/clint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clint_ctrl
// Purpose  : Core-local interrupt/exception controller. Drives the CSR file's
//            clint write port to sequence trap entry (ECALL, EBREAK, timer
//            interrupt) and MRET, stalls the pipeline while doing so, and
//            issues a single-cycle PC redirect at the end of each sequence.
// Ports    : clk, rst               - clock, async active-high reset
//            inst_*_i, inst_addr_i  - trap/return triggers and PC in execute
//            irq_timer_i            - level timer interrupt request
//            global_int_en_i        - mstatus.MIE
//            csr_mtvec/mepc/mstatus - live CSR values
//            wb_csr_we_i            - competing write-back CSR write
//            csr_we/waddr/wdata_o   - CSR write port
//            hold_flag_o            - pipeline stall request
//            int_jump_o/int_addr_o  - PC redirect strobe and target
// Revision : 1.0 - initial release
// ============================================================================
module clint_ctrl #(
    parameter int          CSR_ADDR_W     = 32,
    parameter logic [31:0] RESET_PC_DUMMY = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ecall_i,
    input  logic                  inst_ebreak_i,
    input  logic                  inst_mret_i,
    input  logic [31:0]           inst_addr_i,
    input  logic                  irq_timer_i,
    input  logic                  global_int_en_i,
    input  logic [31:0]           csr_mtvec_i,
    input  logic [31:0]           csr_mepc_i,
    input  logic [31:0]           csr_mstatus_i,
    input  logic                  wb_csr_we_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [31:0]           csr_wdata_o,
    output logic                  hold_flag_o,
    output logic                  int_jump_o,
    output logic [31:0]           int_addr_o
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;

    localparam logic [31:0] c_CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] c_CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] c_CAUSE_TIMER  = 32'h8000_0007;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_M_RESTORE = 3'd4,
        S_JUMP      = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic        mret_q;     // selects the redirect target in S_JUMP

    logic        w_sync_trig;
    logic        w_irq_take;
    logic        w_trig;
    logic [11:0] w_waddr;

    // Synchronous triggers always win; the interrupt only fires in a cycle
    // with no synchronous trigger so it stays pending behind them.
    assign w_sync_trig = inst_ecall_i | inst_ebreak_i | inst_mret_i;
    assign w_irq_take  = irq_timer_i & global_int_en_i & ~w_sync_trig;
    assign w_trig      = (state_q == S_IDLE) & (w_sync_trig | w_irq_take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            mret_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_trig) begin
                        pc_q <= inst_addr_i;
                    end
                    if (inst_ecall_i) begin
                        cause_q <= c_CAUSE_ECALL;
                        mret_q  <= 1'b0;
                        state_q <= S_W_MEPC;
                    end else if (inst_ebreak_i) begin
                        cause_q <= c_CAUSE_EBREAK;
                        mret_q  <= 1'b0;
                        state_q <= S_W_MEPC;
                    end else if (inst_mret_i) begin
                        mret_q  <= 1'b1;
                        state_q <= S_M_RESTORE;
                    end else if (w_irq_take) begin
                        cause_q <= c_CAUSE_TIMER;
                        mret_q  <= 1'b0;
                        state_q <= S_W_MEPC;
                    end
                end
                // The CSR file favours the wb port, so a write step only
                // completes in a cycle without a wb write; otherwise repeat.
                S_W_MEPC:    if (!wb_csr_we_i) state_q <= S_W_MSTATUS;
                S_W_MSTATUS: if (!wb_csr_we_i) state_q <= S_W_MCAUSE;
                S_W_MCAUSE:  if (!wb_csr_we_i) state_q <= S_JUMP;
                S_M_RESTORE: if (!wb_csr_we_i) state_q <= S_JUMP;
                S_JUMP:      state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        csr_we_o    = 1'b0;
        w_waddr     = 12'h0;
        csr_wdata_o = 32'h0;
        int_jump_o  = 1'b0;
        int_addr_o  = RESET_PC_DUMMY;
        hold_flag_o = w_trig | (state_q != S_IDLE);
        case (state_q)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                w_waddr     = c_ADDR_MEPC;
                csr_wdata_o = pc_q;
            end
            S_W_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0
                csr_we_o    = 1'b1;
                w_waddr     = c_ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                               csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                w_waddr     = c_ADDR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            S_M_RESTORE: begin
                // MIE <= MPIE, MPIE <= 1
                csr_we_o    = 1'b1;
                w_waddr     = c_ADDR_MSTATUS;
                csr_wdata_o = {csr_mstatus_i[31:8], 1'b1,
                               csr_mstatus_i[6:4], csr_mstatus_i[7],
                               csr_mstatus_i[2:0]};
            end
            S_JUMP: begin
                int_jump_o = 1'b1;
                int_addr_o = mret_q ? csr_mepc_i
                                    : {csr_mtvec_i[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign csr_waddr_o = CSR_ADDR_W'(w_waddr);

endmodule
`default_nettype wire

// File: tb/tb_clint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_ctrl
// Purpose  : Scoreboard bench for clint_ctrl. Stimulus tasks push the expected
//            CSR writes / redirects (with their cycle numbers) and per-cycle
//            stall expectations; a monitor on the falling edge pops and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_ctrl;

    logic        clk;
    logic        rst;
    logic        inst_ecall_i, inst_ebreak_i, inst_mret_i;
    logic [31:0] inst_addr_i;
    logic        irq_timer_i, global_int_en_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        wb_csr_we_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_flag_o;
    logic        int_jump_o;
    logic [31:0] int_addr_o;

    clint_ctrl #(
        .CSR_ADDR_W    (32),
        .RESET_PC_DUMMY(32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_ecall_i   (inst_ecall_i),
        .inst_ebreak_i  (inst_ebreak_i),
        .inst_mret_i    (inst_mret_i),
        .inst_addr_i    (inst_addr_i),
        .irq_timer_i    (irq_timer_i),
        .global_int_en_i(global_int_en_i),
        .csr_mtvec_i    (csr_mtvec_i),
        .csr_mepc_i     (csr_mepc_i),
        .csr_mstatus_i  (csr_mstatus_i),
        .wb_csr_we_i    (wb_csr_we_i),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .hold_flag_o    (hold_flag_o),
        .int_jump_o     (int_jump_o),
        .int_addr_o     (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          jmp;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;
    bit   exp_hold[1024];
    exp_t m_e;
    bit   m_ok;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall flag every cycle, then any write/jump against the queue.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            n_cmp++;
            if (hold_flag_o !== exp_hold[cyc]) begin
                n_err++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, hold_flag_o, exp_hold[cyc]);
            end
            if (csr_we_o || int_jump_o) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out cyc=%0d we=%b jump=%b waddr=%h wdata=%h iaddr=%h",
                             cyc, csr_we_o, int_jump_o, csr_waddr_o, csr_wdata_o, int_addr_o);
                end else begin
                    m_e = q.pop_front();
                    if (m_e.jmp)
                        m_ok = (m_e.cyc == cyc) && int_jump_o === 1'b1 && csr_we_o === 1'b0 &&
                               int_addr_o === m_e.addr;
                    else
                        m_ok = (m_e.cyc == cyc) && int_jump_o === 1'b0 && csr_we_o === 1'b1 &&
                               csr_waddr_o === m_e.addr && csr_wdata_o === m_e.data &&
                               int_addr_o === 32'h0;
                    if (!m_ok) begin
                        n_err++;
                        $display("FAIL %s cyc=%0d got(jump=%b we=%b waddr=%h wdata=%h iaddr=%h) exp(cyc=%0d addr=%h data=%h)",
                                 m_e.jmp ? "jump" : "csr_write", cyc, int_jump_o, csr_we_o,
                                 csr_waddr_o, csr_wdata_o, int_addr_o, m_e.cyc, m_e.addr, m_e.data);
                    end
                end
            end else begin
                n_cmp++;
                if (csr_waddr_o !== 32'h0 || csr_wdata_o !== 32'h0 || int_addr_o !== 32'h0) begin
                    n_err++;
                    $display("FAIL idle_outputs cyc=%0d waddr=%h wdata=%h iaddr=%h exp=0/0/0",
                             cyc, csr_waddr_o, csr_wdata_o, int_addr_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (csr_we_o !== 1'b0 || csr_waddr_o !== 32'h0 || csr_wdata_o !== 32'h0 ||
            hold_flag_o !== 1'b0 || int_jump_o !== 1'b0 || int_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL %s got we=%b waddr=%h wdata=%h hold=%b jump=%b iaddr=%h exp all 0",
                     name, csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, int_jump_o, int_addr_o);
        end
    endtask

    // Trap entry. Called just after a rising edge; that cycle is T.
    // ncol = number of wb collisions applied during the mstatus write.
    task automatic trap(input logic ec, input logic eb, input logic ir, input logic mie,
                        input logic [31:0] pc, input logic [31:0] mtvec,
                        input logic [31:0] mst, input logic [31:0] exp_mst,
                        input logic [31:0] exp_cause, input logic [31:0] exp_jump,
                        input int ncol);
        int t;
        t = cyc;
        inst_ecall_i    = ec;
        inst_ebreak_i   = eb;
        irq_timer_i     = ir;
        global_int_en_i = mie;
        inst_addr_i     = pc;
        csr_mtvec_i     = mtvec;
        csr_mstatus_i   = mst;
        q.push_back('{t + 1, 1'b0, 32'h341, pc});
        for (int i = 0; i <= ncol; i++) q.push_back('{t + 2 + i, 1'b0, 32'h300, exp_mst});
        q.push_back('{t + 3 + ncol, 1'b0, 32'h342, exp_cause});
        q.push_back('{t + 4 + ncol, 1'b1, exp_jump, 32'h0});
        for (int k = t; k <= t + 4 + ncol; k++) exp_hold[k] = 1'b1;
        tick();                               // T+1
        inst_ecall_i    = 1'b0;
        inst_ebreak_i   = 1'b0;
        global_int_en_i = 1'b0;               // MIE now cleared by the trap
        inst_addr_i     = 32'hDEAD_BEEF;      // PC must have been captured
        tick();                               // T+2 : mstatus write
        if (ncol > 0) wb_csr_we_i = 1'b1;
        repeat (ncol) tick();
        wb_csr_we_i = 1'b0;
        repeat (3) tick();                    // IDLE
        tick();
    endtask

    task automatic mret(input logic [31:0] mst, input logic [31:0] mepc,
                        input logic [31:0] exp_mst);
        int t;
        t = cyc;
        inst_mret_i   = 1'b1;
        csr_mstatus_i = mst;
        csr_mepc_i    = mepc;
        q.push_back('{t + 1, 1'b0, 32'h300, exp_mst});
        q.push_back('{t + 2, 1'b1, mepc, 32'h0});
        for (int k = t; k <= t + 2; k++) exp_hold[k] = 1'b1;
        tick();
        inst_mret_i = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int t;
        rst = 1'b1;
        inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0; inst_addr_i = 0;
        irq_timer_i = 0; global_int_en_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0;
        csr_mstatus_i = 0; wb_csr_we_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // ECALL
        trap(1, 0, 0, 1, 32'h100, 32'h205, 32'h8, 32'h80, 32'd11, 32'h204, 0);
        // Timer interrupt taken
        trap(0, 0, 1, 1, 32'h2000, 32'h800, 32'h8, 32'h80, 32'h8000_0007, 32'h800, 0);
        // Timer interrupt masked: no action
        irq_timer_i = 1'b1; global_int_en_i = 1'b0;
        repeat (4) tick();
        irq_timer_i = 1'b0;
        tick();
        // MRET
        mret(32'h80, 32'h3000, 32'h88);
        mret(32'h1800, 32'h44, 32'h1880);
        // EBREAK, MIE=0 so MPIE becomes 0; mtvec low bits dropped
        trap(0, 1, 0, 0, 32'h500, 32'hFFFF_FFFF, 32'h80, 32'h0, 32'd3, 32'hFFFF_FFFC, 0);
        // Two wb collisions during the mstatus write
        trap(1, 0, 0, 1, 32'h600, 32'h700, 32'h1808, 32'h1880, 32'd11, 32'h700, 2);
        // ECALL and irq together: ECALL wins, irq stays pending but masked
        trap(1, 0, 1, 1, 32'h400, 32'h1000, 32'h88, 32'h80, 32'd11, 32'h1000, 0);
        repeat (3) tick();
        irq_timer_i = 1'b0;
        tick();

        // Reset while in W_MCAUSE
        t = cyc;
        inst_ecall_i  = 1'b1;
        inst_addr_i   = 32'h900;
        csr_mtvec_i   = 32'hA00;
        csr_mstatus_i = 32'h8;
        q.push_back('{t + 1, 1'b0, 32'h341, 32'h900});
        q.push_back('{t + 2, 1'b0, 32'h300, 32'h80});
        for (int k = t; k <= t + 2; k++) exp_hold[k] = 1'b1;
        tick();
        inst_ecall_i = 1'b0;
        tick();
        tick();                               // T+3 : W_MCAUSE
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_seq");
        tick();
        check_reset_outputs("reset_held");
        rst = 1'b0;
        repeat (6) tick();

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations got=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clint_ctrl.md
Name: clint_ctrl

Overview:
- Core-local interrupt/exception controller; the initiator side of the CSR register file's clint port.
- Sequences trap entry for ECALL, EBREAK and the timer interrupt: writes mepc, mstatus and mcause one per cycle, then redirects the PC to mtvec.
- Sequences MRET: restores mstatus, then redirects to mepc.
- Holds the pipeline for the whole sequence. Retries any CSR write that collides with a write-back CSR write, because the register file gives the wb port priority.

Parameters:
- CSR_ADDR_W, 32, width of CSR address bus; only bits [11:0] are decoded.
- RESET_PC_DUMMY, 32'h0, value driven on int_addr_o when no jump is active.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- inst_ecall_i  in  1  ECALL in execute this cycle
- inst_ebreak_i  in  1  EBREAK in execute this cycle
- inst_mret_i  in  1  MRET in execute this cycle
- inst_addr_i  in  32  PC of the instruction in execute
- irq_timer_i  in  1  timer interrupt request, level
- global_int_en_i  in  1  mstatus.MIE from the CSR file
- csr_mtvec_i  in  32  live mtvec
- csr_mepc_i  in  32  live mepc
- csr_mstatus_i  in  32  live mstatus
- wb_csr_we_i  in  1  write-back stage CSR write this cycle
- csr_we_o  out  1  CSR write strobe to the CSR file
- csr_waddr_o  out  CSR_ADDR_W  CSR write address
- csr_wdata_o  out  32  CSR write data
- hold_flag_o  out  1  stall request to the pipeline controller
- int_jump_o  out  1  single-cycle PC redirect strobe
- int_addr_o  out  32  redirect target

Behaviour:
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, M_RESTORE, JUMP.
- Reset (async, any state, mid-sequence included):
  - state=IDLE.
  - All outputs 0, except int_addr_o=RESET_PC_DUMMY.
  - Captured pc/cause registers cleared.
- Trigger is sampled in IDLE only. Priority: ecall > ebreak > mret > interrupt.
  - Interrupt is taken iff irq_timer_i && global_int_en_i && no synchronous trigger in the same cycle.
- Trigger cycle T:
  - Capture pc=inst_addr_i.
  - Capture cause: ecall 32'd11, ebreak 32'd3, timer 32'h8000_0007.
  - Next state: W_MEPC for traps, M_RESTORE for mret.
- hold_flag_o:
  - Combinationally 1 in the trigger cycle.
  - 1 in every non-IDLE state, JUMP included.
  - 0 otherwise.
- W_MEPC: csr_we_o=1, waddr=0x341, wdata=captured pc.
- W_MSTATUS: waddr=0x300, wdata = mstatus with bit7 (MPIE) set to mstatus[3] and bit3 (MIE) cleared; all other bits pass from csr_mstatus_i.
- W_MCAUSE: waddr=0x342, wdata=captured cause.
- M_RESTORE: waddr=0x300, wdata = mstatus with bit3 set to mstatus[7] and bit7 set to 1.
- Collision rule: in any write state, if wb_csr_we_i=1:
  - csr_we_o is still driven.
  - The state does not advance, so the same write repeats next cycle.
  - The step completes only in a cycle where wb_csr_we_i=0.
- Trap sequence then goes to JUMP: int_jump_o=1, int_addr_o={csr_mtvec_i[31:2],2'b00}, then IDLE.
- MRET sequence then goes to JUMP: int_addr_o=csr_mepc_i, then IDLE.
- Nominal latency with no collisions:
  - Trap: write cycles T+1..T+3, jump at T+4, IDLE at T+5.
  - MRET: write at T+1, jump at T+2.
- Outside write states csr_we_o=0, waddr=0, wdata=0. Outside JUMP int_jump_o=0.
- Triggers arriving while not in IDLE are ignored. The interrupt is level, so it is re-evaluated on return to IDLE; by then MIE is 0 after a trap, so there is no re-entry.
- Simultaneous ecall and irq: the ecall wins; the irq stays pending.

Test Plan:
- Reset then ECALL at pc=0x100, mtvec=0x205, mstatus=0x8 → writes (0x341,0x100), (0x300,0x80), (0x342,11) on T+1..T+3; jump to 0x204 at T+4; hold high T..T+4.
- irq_timer_i=1, MIE=1, pc=0x2000 → mcause write 0x8000_0007, mepc write 0x2000; irq with MIE=0 → no action, hold stays 0.
- MRET with mstatus=0x80, mepc=0x3000 → write (0x300,0x88) at T+1; jump to 0x3000 at T+2.
- wb_csr_we_i=1 during W_MSTATUS for 2 cycles → mstatus write repeats 3 cycles; jump delayed to T+6; other writes unchanged.
- ECALL and irq together → mcause=11; asserting rst in W_MCAUSE → immediate IDLE, all outputs 0, no jump.
